draw_rect: RTL and testbench



---
 rtl/draw_rect_if.sv | 32 +++
 rtl/draw_rect.sv | 101 ++++++++++
 tb/tb_draw_rect.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/draw_rect_if.sv
// Handshake and pixel bus between game logic (master) and the rectangle
// rasteriser (slave).
interface draw_rect_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SIZE_W   = 5,
  parameter int COLOUR_W = 3
);
  logic                start;
  logic [X_W-1:0]      x_origin;
  logic [Y_W-1:0]      y_origin;
  logic [SIZE_W-1:0]   rect_w;
  logic [SIZE_W-1:0]   rect_h;
  logic [COLOUR_W-1:0] colour;
  logic [1:0]          mode;
  logic                busy;
  logic                done;
  logic                plot;
  logic [X_W-1:0]      x_out;
  logic [Y_W-1:0]      y_out;
  logic [COLOUR_W-1:0] colour_out;

  modport master (
    output start, x_origin, y_origin, rect_w, rect_h, colour, mode,
    input  busy, done, plot, x_out, y_out, colour_out
  );

  modport slave (
    input  start, x_origin, y_origin, rect_w, rect_h, colour, mode,
    output busy, done, plot, x_out, y_out, colour_out
  );
endinterface

// File: rtl/draw_rect.sv
// Rectangle rasteriser: latches a request on start, then walks the rectangle
// in raster order, one registered pixel per clock, in fill / outline / erase.
module draw_rect #(
  parameter int                 X_W       = 8,
  parameter int                 Y_W       = 7,
  parameter int                 SIZE_W    = 5,
  parameter int                 COLOUR_W  = 3,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
  input  logic        clk,
  input  logic        reset_n,
  draw_rect_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;

  state_t              state;
  logic [X_W-1:0]      x0;
  logic [Y_W-1:0]      y0;
  logic [SIZE_W-1:0]   w;
  logic [SIZE_W-1:0]   h;
  logic [COLOUR_W-1:0] col;
  logic                outline;
  logic [SIZE_W-1:0]   cx;
  logic [SIZE_W-1:0]   cy;

  logic last_col;
  logic last_row;
  logic edge_px;

  // Position flags for the current pixel; edge_px drives the outline mask.
  always_comb begin
    last_col = (cx == w - SIZE_W'(1));
    last_row = (cy == h - SIZE_W'(1));
    edge_px  = (cx == '0) || last_col || (cy == '0) || last_row;
  end

  // Control FSM with registered pixel outputs. The !done guard in IDLE drops
  // a start that arrives in the same cycle as the completion pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      x0             <= '0;
      y0             <= '0;
      w              <= '0;
      h              <= '0;
      col            <= '0;
      outline        <= 1'b0;
      cx             <= '0;
      cy             <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.plot       <= 1'b0;
      bus.x_out      <= '0;
      bus.y_out      <= '0;
      bus.colour_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start && !bus.done) begin
            x0       <= bus.x_origin;
            y0       <= bus.y_origin;
            w        <= bus.rect_w;
            h        <= bus.rect_h;
            col      <= (bus.mode == 2'b10) ? BG_COLOUR : bus.colour;
            outline  <= (bus.mode == 2'b01);
            cx       <= '0;
            cy       <= '0;
            bus.busy <= 1'b1;
            state    <= (bus.rect_w == '0 || bus.rect_h == '0) ? FINISH : DRAW;
          end
        end
        DRAW: begin
          bus.plot       <= !outline || edge_px;
          bus.x_out      <= x0 + X_W'(cx);
          bus.y_out      <= y0 + Y_W'(cy);
          bus.colour_out <= col;
          if (last_col) begin
            cx <= '0;
            if (last_row) state <= FINISH;
            else          cy    <= cy + SIZE_W'(1);
          end else begin
            cx <= cx + SIZE_W'(1);
          end
        end
        FINISH: begin
          bus.done       <= 1'b1;
          bus.busy       <= 1'b0;
          bus.plot       <= 1'b0;
          bus.x_out      <= '0;
          bus.y_out      <= '0;
          bus.colour_out <= '0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_rect.sv
// Directed bench for draw_rect: a table of rectangles with hand-computed
// plot counts / corner pixels, per-pixel raster checks, plus hand-written
// sequences for mid-draw start, start-on-done and mid-draw reset.
module tb_draw_rect;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  draw_rect_if #(.X_W(8), .Y_W(7), .SIZE_W(5), .COLOUR_W(3)) bus ();

  draw_rect #(.X_W(8), .Y_W(7), .SIZE_W(5), .COLOUR_W(3), .BG_COLOUR(3'd0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int x, y, w, h, col, mode;
    int plots, fx, fy, lx, ly, ecol;
  } vec_t;

  vec_t tbl [8];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive_req(input int x, y, w, h, col, mode, input logic st);
    bus.x_origin = 8'(x);
    bus.y_origin = 7'(y);
    bus.rect_w   = 5'(w);
    bus.rect_h   = 5'(h);
    bus.colour   = 3'(col);
    bus.mode     = 2'(mode);
    bus.start    = st;
  endtask

  // Issue one draw and check every cycle through the done pulse.
  // disturb: pulse start with different inputs mid-draw.
  // start_at_done: present a start in the done cycle, which must be ignored.
  task automatic run_draw(input vec_t v, input bit disturb, input bit start_at_done);
    int n, cx, cy, ex, ey, ep, plots, fx, fy, lx, ly, cbad;
    logic [18:0] act, exp;
    n = v.w * v.h;
    plots = 0; fx = -1; fy = -1; lx = -1; ly = -1; cbad = 0;
    @(negedge clk);
    drive_req(v.x, v.y, v.w, v.h, v.col, v.mode, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    chk("plot_latch_cycle", bus.plot, 0);
    for (int k = 2; k <= n + 3; k++) begin
      @(negedge clk);
      if (k <= n + 1) begin
        cx = (k - 2) % v.w;
        cy = (k - 2) / v.w;
        ex = (v.x + cx) % 256;
        ey = (v.y + cy) % 128;
        ep = (v.mode != 1 || cx == 0 || cx == v.w - 1 || cy == 0 || cy == v.h - 1) ? 1 : 0;
        act = {bus.plot, bus.x_out, bus.y_out, bus.colour_out};
        exp = {1'(ep), 8'(ex), 7'(ey), 3'(v.ecol)};
        chk("pixel", act, exp);
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) cbad++;
        if (bus.plot) begin
          plots++;
          if (fx < 0) begin fx = bus.x_out; fy = bus.y_out; end
          lx = bus.x_out; ly = bus.y_out;
        end
      end else if (k == n + 2) begin
        chk("done_pulse", bus.done, 1);
        chk("busy_at_done", bus.busy, 0);
        chk("plot_at_done", bus.plot, 0);
        if (start_at_done) drive_req(1, 1, 1, 1, 7, 0, 1'b1);
      end else begin
        bus.start = 1'b0;
        chk("done_one_cycle", bus.done, 0);
        chk("idle_after_done", {bus.busy, bus.plot, bus.x_out, bus.y_out, bus.colour_out}, 0);
      end
      if (disturb && k == 5) drive_req(99, 99, 2, 2, 1, 2, 1'b1);
      if (disturb && k == 6) bus.start = 1'b0;
    end
    chk("busy_done_during_draw", cbad, 0);
    chk("plot_count", plots, v.plots);
    if (v.plots > 0) begin
      chk("first_pixel", fx * 1000 + fy, v.fx * 1000 + v.fy);
      chk("last_pixel", lx * 1000 + ly, v.lx * 1000 + v.ly);
    end
  endtask

  initial begin
    int dones;
    tbl[0] = '{10, 20, 4, 4, 5, 0, 16, 10, 20, 13, 23, 5};   // fill
    tbl[1] = '{0, 0, 3, 3, 2, 1, 8, 0, 0, 2, 2, 2};          // outline
    tbl[2] = '{50, 60, 2, 2, 7, 2, 4, 50, 60, 51, 61, 0};    // erase -> BG
    tbl[3] = '{10, 10, 0, 5, 3, 0, 0, 0, 0, 0, 0, 0};        // zero width
    tbl[4] = '{254, 3, 4, 1, 1, 0, 4, 254, 3, 1, 3, 1};      // x wrap
    tbl[5] = '{5, 5, 1, 1, 3, 1, 1, 5, 5, 5, 5, 3};          // 1x1 outline
    tbl[6] = '{100, 120, 2, 3, 6, 3, 6, 100, 120, 101, 122, 6}; // mode 11
    tbl[7] = '{7, 126, 4, 3, 4, 1, 10, 7, 126, 10, 0, 4};    // outline, y wrap

    drive_req(0, 0, 0, 0, 0, 0, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {bus.busy, bus.done, bus.plot, bus.x_out, bus.y_out, bus.colour_out}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_no_start", {bus.busy, bus.done, bus.plot}, 0);

    for (int i = 0; i < 8; i++) run_draw(tbl[i], 1'b0, 1'b0);

    // Start pulsed mid-draw with new inputs: original fill must complete.
    run_draw(tbl[0], 1'b1, 1'b0);
    // Start presented in the done cycle is dropped.
    run_draw(tbl[5], 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("start_on_done_ignored", bus.busy, 0);
    end

    // Reset on the 7th pixel of a 4x4 fill: abort with no done pulse.
    @(negedge clk);
    drive_req(10, 20, 4, 4, 5, 0, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pixel7_before_reset", {bus.plot, bus.x_out, bus.y_out}, {1'b1, 8'd12, 7'd21});
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("reset_abort_plot", bus.plot, 0);
    chk("reset_abort_busy", bus.busy, 0);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.plot) dones++;
    end
    chk("no_done_after_abort", dones, 0);
    run_draw(tbl[2], 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
